// File: rtl/dct16_block_collector_if.sv
// Handshake bundle between the DCT16 scaling stage, the block collector and its consumer.
// The master side drives the sample stream and out_ready; the slave is the collector.
interface dct16_block_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
);
  localparam int IDX_W = $clog2(N);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_sample;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_sample;
  logic [IDX_W-1:0]             out_index;
  logic                         out_last;
  logic                         overflow;

  modport master (
    output in_valid, in_sample, out_ready,
    input  out_valid, out_sample, out_index, out_last, overflow
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output out_valid, out_sample, out_index, out_last, overflow
  );
endinterface

// File: rtl/dct16_block_collector.sv
// Rescales the DCT16 output stream with a saturating left shift, packs it into N-sample
// blocks in a ping-pong buffer and hands completed blocks out one coefficient per transfer.
module dct16_block_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int N           = 16,
  parameter int SCALE_SHIFT = 1
) (
  input logic                    clk,
  input logic                    rst,
  dct16_block_collector_if.slave bus
);
  localparam int              IDX_W    = $clog2(N);
  localparam int              WIDE_W   = DATA_WIDTH + SCALE_SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {FILL, DROP} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             rd_idx;
  logic                         wr_buf;
  logic                         rd_buf;
  logic [1:0]                   full;
  logic                         overflow_r;
  logic signed [DATA_WIDTH-1:0] mem [2][N];

  logic transfer;
  logic release_rd;
  logic start_blocked;
  logic wr_en;

  function automatic logic signed [DATA_WIDTH-1:0] rescale(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [WIDE_W-1:0] wide;
    wide = WIDE_W'(x);
    wide = wide <<< SCALE_SHIFT;
    // Bits above the output sign must all match the sign, otherwise the shift overflowed.
    if (wide[WIDE_W-1:DATA_WIDTH-1] != {(SCALE_SHIFT + 1){wide[WIDE_W-1]}})
      return wide[WIDE_W-1] ? {1'b1, {(DATA_WIDTH - 1){1'b0}}} : {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    return wide[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    transfer   = full[rd_buf] && bus.out_ready;
    release_rd = transfer && (rd_idx == LAST_IDX);
    // A buffer whose last word leaves on this edge is free for the new block.
    start_blocked = (wr_idx == '0) && full[wr_buf] && !(release_rd && (rd_buf == wr_buf));
    wr_en = bus.in_valid && (state == FILL) && !start_blocked;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_buf][wr_idx] <= rescale(bus.in_sample);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_idx     <= '0;
      rd_idx     <= '0;
      wr_buf     <= 1'b0;
      rd_buf     <= 1'b0;
      full       <= 2'b00;
      overflow_r <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        case (state)
          FILL: begin
            if (start_blocked) begin
              state      <= DROP;
              overflow_r <= 1'b1;
            end else if (wr_idx == LAST_IDX) begin
              full[wr_buf] <= 1'b1;
              wr_buf       <= ~wr_buf;
            end
          end
          DROP: begin
            // Keep counting so the next accepted block starts on a block boundary.
            if (wr_idx == LAST_IDX)
              state <= FILL;
          end
          default: state <= FILL;
        endcase
      end
      if (transfer) begin
        rd_idx <= release_rd ? '0 : rd_idx + 1'b1;
        if (release_rd) begin
          full[rd_buf] <= 1'b0;
          rd_buf       <= ~rd_buf;
        end
      end
    end
  end

  assign bus.out_valid  = full[rd_buf];
  assign bus.out_sample = full[rd_buf] ? mem[rd_buf][rd_idx] : '0;
  assign bus.out_index  = full[rd_buf] ? rd_idx : '0;
  assign bus.out_last   = full[rd_buf] && (rd_idx == LAST_IDX);
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_dct16_block_collector.sv
// Directed bench for dct16_block_collector: a block-queue model checked every cycle plus
// literal expectations on the captured output stream.
module tb_dct16_block_collector;
  localparam int DATA_WIDTH  = 16;
  localparam int N           = 16;
  localparam int SCALE_SHIFT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct16_block_collector_if #(.DATA_WIDTH(DATA_WIDTH), .N(N)) bus ();

  dct16_block_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Model state: completed blocks flattened in arrival order, plus the block being assembled.
  int done_q[$];
  int part_q[$];
  int got_q[$];
  int rd_cnt    = 0;
  int cnt_in    = 0;
  bit dropping  = 1'b0;
  bit ovf_m     = 1'b0;
  int last_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int s);
    int v;
    v = s * (2 ** SCALE_SHIFT);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  always @(posedge clk) begin
    bit xfer;
    bit rel;
    int outstanding;
    if (rst) begin
      done_q.delete();
      part_q.delete();
      rd_cnt   = 0;
      cnt_in   = 0;
      dropping = 1'b0;
      ovf_m    = 1'b0;
    end else begin
      xfer        = (done_q.size() > 0) && bus.out_ready;
      rel         = xfer && (rd_cnt == N - 1);
      outstanding = (done_q.size() + rd_cnt) / N;
      if (bus.in_valid) begin
        if (cnt_in == 0) begin
          dropping = (outstanding - (rel ? 1 : 0)) >= 2;
          if (dropping) ovf_m = 1'b1;
        end
        if (!dropping) part_q.push_back(sat(int'(bus.in_sample)));
        cnt_in++;
        if (cnt_in == N) begin
          if (!dropping) foreach (part_q[i]) done_q.push_back(part_q[i]);
          part_q.delete();
          cnt_in = 0;
        end
      end
      if (xfer) begin
        void'(done_q.pop_front());
        rd_cnt = (rd_cnt + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (armed) begin
      exp_v = done_q.size() > 0;
      chk("out_valid", int'(bus.out_valid), int'(exp_v));
      chk("out_sample", int'(bus.out_sample), exp_v ? done_q[0] : 0);
      chk("out_index", int'(bus.out_index), exp_v ? rd_cnt : 0);
      chk("out_last", int'(bus.out_last), int'(exp_v && rd_cnt == N - 1));
      chk("overflow", int'(bus.overflow), int'(ovf_m));
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(int'(bus.out_sample));
        if (bus.out_last) last_cnt++;
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_q(input int vals[$]);
    foreach (vals[i]) begin
      bus.in_valid  = 1'b1;
      bus.in_sample = DATA_WIDTH'(vals[i]);
      cycle(1);
    end
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
  endtask

  task automatic send(input int first, input int count);
    int vals[$];
    for (int i = 0; i < count; i++) vals.push_back(first + i);
    send_q(vals);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sat_in[$];
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cycle(2);
    rst = 1'b0;
    armed = 1'b1;
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_overflow", int'(bus.overflow), 0);

    // Basic block
    bus.out_ready = 1'b1;
    got_q.delete();
    last_cnt = 0;
    send(0, N);
    chk("latency_valid", int'(bus.out_valid), 1);
    cycle(20);
    chk("basic_len", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("basic_val", got_q[i], 2 * i);
    chk("basic_last", last_cnt, 1);
    chk("basic_drop", int'(bus.out_valid), 0);

    // Saturation
    got_q.delete();
    sat_in = '{100, 20480, -20000, -16384, 16383, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_q(sat_in);
    cycle(20);
    chk("sat_len", got_q.size(), 16);
    if (got_q.size() >= 5) begin
      chk("sat_100", got_q[0], 200);
      chk("sat_pos", got_q[1], 32767);
      chk("sat_neg", got_q[2], -32768);
      chk("sat_edge_neg", got_q[3], -32768);
      chk("sat_edge_pos", got_q[4], 32766);
    end

    // Backpressure
    got_q.delete();
    bus.out_ready = 1'b0;
    send(1000, N);
    send(2000, N);
    cycle(5);
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_hold", int'(bus.out_sample), 2000);
    bus.out_ready = 1'b1;
    cycle(40);
    chk("bp_len", got_q.size(), 32);
    if (got_q.size() == 32) begin
      chk("bp_first_b", got_q[16], 4000);
      chk("bp_end", got_q[31], 4030);
    end
    chk("bp_overflow", int'(bus.overflow), 0);

    // Same-edge release
    got_q.delete();
    bus.out_ready = 1'b0;
    send(10, N);
    send(50, N);
    bus.out_ready = 1'b1;
    cycle(15);
    send(90, N);
    cycle(40);
    chk("rel_len", got_q.size(), 48);
    if (got_q.size() == 48) begin
      chk("rel_a", got_q[15], 50);
      chk("rel_b", got_q[16], 100);
      chk("rel_e", got_q[32], 180);
      chk("rel_e_end", got_q[47], 210);
    end
    chk("rel_overflow", int'(bus.overflow), 0);

    // Overflow
    got_q.delete();
    bus.out_ready = 1'b0;
    send(100, N);
    send(200, N);
    send(300, N);
    chk("ovf_set", int'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    cycle(40);
    send(400, N);
    cycle(25);
    chk("ovf_len", got_q.size(), 48);
    if (got_q.size() == 48) begin
      chk("ovf_a", got_q[0], 200);
      chk("ovf_b", got_q[16], 400);
      chk("ovf_d", got_q[32], 800);
      chk("ovf_d_end", got_q[47], 830);
    end
    chk("ovf_sticky", int'(bus.overflow), 1);

    // Mid-block reset
    got_q.delete();
    bus.out_ready = 1'b0;
    send(500, N);
    send(600, 7);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    chk("mrst_valid", int'(bus.out_valid), 0);
    chk("mrst_overflow", int'(bus.overflow), 0);
    chk("mrst_index", int'(bus.out_index), 0);
    bus.out_ready = 1'b1;
    send(700, N);
    cycle(25);
    chk("mrst_len", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("mrst_first", got_q[0], 1400);
      chk("mrst_end", got_q[15], 1430);
    end

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dct16_block_collector.md
Name: dct16_block_collector

Overview:
Sink-side counterpart of the DCT16 butterfly pipeline. It accepts the unthrottled valid/sample stream leaving the last scaling stage and undoes that stage's arithmetic right shift with a saturating left shift. It packs consecutive samples into N-sample blocks in a ping-pong (double) buffer. Completed blocks are then presented to a downstream consumer over a valid/ready handshake, one coefficient per transfer.

Parameters:
DATA_WIDTH, 16, signed sample width in and out
N, 16, samples per block (power of two, >= 2)
SCALE_SHIFT, 1, left-shift amount restoring the upstream 1/2^SCALE_SHIFT scaling (0 = pass-through)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample strobe; no backpressure to producer
in_sample  in  DATA_WIDTH  signed input sample
out_valid  out  1  a completed block is being presented
out_ready  in  1  consumer accepts out_sample this cycle
out_sample  out  DATA_WIDTH  signed rescaled sample
out_index  out  log2(N)  position of out_sample within its block
out_last  out  1  out_valid && out_index == N-1
overflow  out  1  sticky: at least one whole block was dropped

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_idx, rd_idx, wr_buf, rd_buf are cleared to 0.
  - Both buffer-full flags are cleared, overflow is cleared, and the input FSM goes to FILL.
  - out_valid, out_last, out_index and out_sample read 0 in the following cycle.
  - Buffer contents are don't-care after reset.
  - Reset mid-block discards any partial and completed blocks; nothing is emitted afterwards until a fresh N-sample block completes.
- Rescale: the stored value is in_sample <<< SCALE_SHIFT, computed at DATA_WIDTH+SCALE_SHIFT bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Input FSM, two states, FILL and DROP; wr_idx counts 0..N-1 in both states.
  - In FILL, each in_valid writes the rescaled sample to buf[wr_buf][wr_idx] and increments wr_idx.
  - On the write with wr_idx==N-1: set full[wr_buf], toggle wr_buf, wrap wr_idx to 0.
  - Block-start check: when in_valid arrives with wr_idx==0, the target buffer is checked.
    - If full[wr_buf] is set and that buffer is not being released on the same edge, go to DROP, do not write the sample, and set overflow.
    - A buffer released on the same edge counts as free, so the block is written and nothing is dropped.
  - In DROP, in_valid samples are counted but not stored. On the Nth counted sample, wrap wr_idx to 0 and return to FILL with wr_buf unchanged. This keeps block alignment.
  - in_valid low: no state change.
- Output side (combinational from registered state):
  - out_valid = full[rd_buf].
  - out_sample = buf[rd_buf][rd_idx] when out_valid, else 0.
  - out_index = rd_idx when out_valid, else 0.
- Transfer = out_valid && out_ready. On a transfer rd_idx increments. On the transfer with rd_idx==N-1: clear full[rd_buf], toggle rd_buf, wrap rd_idx to 0.
- While out_valid && !out_ready, out_sample, out_index and out_last hold stable. out_ready while !out_valid is ignored.
- Latency: if the last sample of a block is accepted at edge k, out_valid is high after edge k and the first transfer can occur at edge k+1.
- A block still being read stays intact while the other buffer fills. Write and read of different buffers on the same edge are independent.
- Ordering: blocks are emitted in arrival order, and samples within a block in arrival order.
- overflow clears only on rst.

Test Plan:
- Basic block: reset, 16 consecutive in_valid with samples 0..15, out_ready=1 -> out_valid rises the cycle after the 16th input; outputs 0,2,4,...,30 with out_index 0..15; out_last only on value 30; out_valid then drops.
- Saturation (DATA_WIDTH=16, SHIFT=1): inputs 100, 20480, -20000, -16384, 16383 -> 200, 32767 (0x7FFF), -32768 (0x8000), -32768, 32766.
- Backpressure: two back-to-back blocks, out_ready held 0 -> out_valid stays 1 and out_sample holds block0[0]; release out_ready -> 32 outputs in order, no overflow.
- Overflow: three back-to-back blocks A,B,C with out_ready=0 during C -> C discarded and overflow=1; then block D with out_ready=1 -> output order is A, B, D; overflow stays 1.
- Same-edge release: both buffers full and the final read of A coincides with the first sample of new block E -> E is stored and emitted after B; overflow stays 0.
- Mid-block reset: assert rst after 7 input samples and with one block pending -> out_valid=0 and overflow=0 next cycle; the next 16 samples form a correct block starting at out_index 0.
